// File: rtl/n_bit_register_file_pkg.sv
//------------------------------------------------------------------------------
// Package  : n_bit_register_file_pkg
// Brief    : Lane-width constant and byte-merge helper for n_bit_register_file.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package n_bit_register_file_pkg;

  localparam int unsigned c_LANE_W = 8;
  // Widest word the merge helper handles; callers cast to and from this width.
  localparam int unsigned c_MAX_W  = 1024;
  localparam int unsigned c_MAX_NB = c_MAX_W / c_LANE_W;

  function automatic logic [c_MAX_W-1:0] byte_merge(
    input logic [c_MAX_W-1:0]  old_word,
    input logic [c_MAX_W-1:0]  new_word,
    input logic [c_MAX_NB-1:0] strb
  );
    logic [c_MAX_W-1:0] w_merged;
    w_merged = old_word;
    for (int i = 0; i < int'(c_MAX_NB); i++) begin
      if (strb[i]) begin
        w_merged[i*c_LANE_W +: c_LANE_W] = new_word[i*c_LANE_W +: c_LANE_W];
      end
    end
    return w_merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : regfile_scoreboard
// Brief    : Per-register pending bits, population counter and busy lookups.
//            Macro N_BIT_REGISTER_FILE_BYPASS_EN forwards same-cycle set/clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard #(
  parameter int DEPTH    = 16,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  input  logic          SET_EN,
  input  logic [AW-1:0] SET_A,
  input  logic          CLR_EN,
  input  logic [AW-1:0] CLR_A,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic          BUSY1,
  output logic          BUSY2,
  output logic [AW:0]   PENDING_CNT
);

  logic [DEPTH-1:0] r_pend;
  logic [AW:0]      r_cnt;
  logic [DEPTH-1:0] w_next;
  logic             w_inc;
  logic             w_dec;
  logic             w_busy1;
  logic             w_busy2;

  // Set wins over clear so a new producer keeps the register reserved.
  always_comb begin
    w_next = r_pend;
    if (CLR_EN) w_next[CLR_A] = 1'b0;
    if (SET_EN) w_next[SET_A] = 1'b1;
    w_inc = SET_EN && !r_pend[SET_A];
    w_dec = CLR_EN && r_pend[CLR_A] && !(SET_EN && (SET_A == CLR_A));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else if (CLR) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_next;
      r_cnt  <= r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end

  always_comb begin
`ifdef N_BIT_REGISTER_FILE_BYPASS_EN
    w_busy1 = w_next[RA1];
    w_busy2 = w_next[RA2];
`else
    w_busy1 = r_pend[RA1];
    w_busy2 = r_pend[RA2];
`endif
    if (ZERO_REG && (RA1 == '0)) w_busy1 = 1'b0;
    if (ZERO_REG && (RA2 == '0)) w_busy2 = 1'b0;
  end

  assign BUSY1       = w_busy1;
  assign BUSY2       = w_busy2;
  assign PENDING_CNT = r_cnt;

endmodule

`default_nettype wire

// File: rtl/n_bit_register_file.sv
//------------------------------------------------------------------------------
// Module   : n_bit_register_file
// Brief    : DEPTH x N register file, byte-strobed write, two async reads,
//            pending scoreboard. Macro N_BIT_REGISTER_FILE_BYPASS_EN adds
//            write-to-read forwarding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module n_bit_register_file
  import n_bit_register_file_pkg::*;
#(
  parameter int N        = 32,
  parameter int DEPTH    = 16,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = N / 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  input  logic          WE,
  input  logic [AW-1:0] WA,
  input  logic [N-1:0]  WD,
  input  logic [NB-1:0] WSTRB,
  input  logic          RES,
  input  logic [AW-1:0] RES_A,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic [N-1:0]  RD1,
  output logic [N-1:0]  RD2,
  output logic          BUSY1,
  output logic          BUSY2,
  output logic [AW:0]   PENDING_CNT
);

  logic [N-1:0] r_mem [DEPTH];
  logic         w_wr_en;
  logic         w_res_en;
  logic [N-1:0] w_merged;
  logic [N-1:0] w_rd1;
  logic [N-1:0] w_rd2;

  // Forced-zero register 0 swallows writes and reservations entirely.
  assign w_wr_en  = WE  && !(ZERO_REG && (WA == '0));
  assign w_res_en = RES && !(ZERO_REG && (RES_A == '0));
  assign w_merged = N'(byte_merge(c_MAX_W'(r_mem[WA]), c_MAX_W'(WD), c_MAX_NB'(WSTRB)));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (CLR) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[WA] <= w_merged;
    end
  end

  always_comb begin
    w_rd1 = r_mem[RA1];
    w_rd2 = r_mem[RA2];
`ifdef N_BIT_REGISTER_FILE_BYPASS_EN
    if (w_wr_en && (WA == RA1)) w_rd1 = w_merged;
    if (w_wr_en && (WA == RA2)) w_rd2 = w_merged;
`endif
    if (ZERO_REG && (RA1 == '0)) w_rd1 = '0;
    if (ZERO_REG && (RA2 == '0)) w_rd2 = '0;
  end

  assign RD1 = w_rd1;
  assign RD2 = w_rd2;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .CLK         (CLK),
    .RST         (RST),
    .CLR         (CLR),
    .SET_EN      (w_res_en),
    .SET_A       (RES_A),
    .CLR_EN      (w_wr_en),
    .CLR_A       (WA),
    .RA1         (RA1),
    .RA2         (RA2),
    .BUSY1       (BUSY1),
    .BUSY2       (BUSY2),
    .PENDING_CNT (PENDING_CNT)
  );

endmodule

`default_nettype wire

// File: tb/tb_n_bit_register_file.sv
//------------------------------------------------------------------------------
// Module   : tb_n_bit_register_file
// Brief    : Directed self-checking bench for n_bit_register_file (ZERO_REG=1).
//            Honours N_BIT_REGISTER_FILE_BYPASS_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_n_bit_register_file;

  logic        CLK;
  logic        RST;
  logic        CLR;
  logic        WE;
  logic [3:0]  WA;
  logic [31:0] WD;
  logic [3:0]  WSTRB;
  logic        RES;
  logic [3:0]  RES_A;
  logic [3:0]  RA1;
  logic [3:0]  RA2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        BUSY1;
  logic        BUSY2;
  logic [4:0]  PENDING_CNT;

  int checks = 0;
  int errors = 0;

  n_bit_register_file #(
    .N        (32),
    .DEPTH    (16),
    .ZERO_REG (1'b1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CLR         (CLR),
    .WE          (WE),
    .WA          (WA),
    .WD          (WD),
    .WSTRB       (WSTRB),
    .RES         (RES),
    .RES_A       (RES_A),
    .RA1         (RA1),
    .RA2         (RA2),
    .RD1         (RD1),
    .RD2         (RD2),
    .BUSY1       (BUSY1),
    .BUSY2       (BUSY2),
    .PENDING_CNT (PENDING_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    WE = 1'b0; RES = 1'b0; CLR = 1'b0; WSTRB = 4'h0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      WE = 1'b1; WA = 4'($urandom); WD = $urandom; WSTRB = 4'hF;
      RES = 1'b1; RES_A = 4'($urandom); RA1 = 4'($urandom); RA2 = 4'($urandom);
      #2;
      checks++;
      if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
        errors++; $display("FAIL reset_rd: got %h/%h expected 0/0", RD1, RD2);
      end
      checks++;
      if (BUSY1 !== 1'b0 || BUSY2 !== 1'b0 || PENDING_CNT !== 5'd0) begin
        errors++; $display("FAIL reset_sb: got busy %b/%b cnt %0d expected 0/0 cnt 0", BUSY1, BUSY2, PENDING_CNT);
      end
    end
    WE = 1'b0; RES = 1'b0; WSTRB = 4'h0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_byte_strobe();
    WE = 1'b1; WA = 4'd3; WD = 32'hAABBCCDD; WSTRB = 4'hF; tick();
    WE = 1'b1; WA = 4'd3; WD = 32'h11223344; WSTRB = 4'b0101; tick();
    RA1 = 4'd3; RA2 = 4'd3; #1;
    checks++;
    if (RD1 !== 32'hAA22CC44) begin
      errors++; $display("FAIL strobe_rd1: got %h expected aa22cc44", RD1);
    end
    checks++;
    if (RD2 !== 32'hAA22CC44) begin
      errors++; $display("FAIL strobe_rd2_same_addr: got %h expected aa22cc44", RD2);
    end
  endtask

  task automatic test_scoreboard();
    RES = 1'b1; RES_A = 4'd5; tick();
    RES = 1'b1; RES_A = 4'd6; tick();
    RA1 = 4'd5; RA2 = 4'd6; #1;
    checks++;
    if (PENDING_CNT !== 5'd2 || BUSY1 !== 1'b1 || BUSY2 !== 1'b1) begin
      errors++; $display("FAIL sb_reserve: got cnt %0d busy %b/%b expected cnt 2 busy 1/1", PENDING_CNT, BUSY1, BUSY2);
    end
    WE = 1'b1; WA = 4'd5; WD = 32'h00000055; WSTRB = 4'hF; RES = 1'b1; RES_A = 4'd7; tick();
    RA1 = 4'd5; RA2 = 4'd7; #1;
    checks++;
    if (PENDING_CNT !== 5'd2 || BUSY1 !== 1'b0 || BUSY2 !== 1'b1 || RD1 !== 32'h00000055) begin
      errors++; $display("FAIL sb_set_clr_diff: got cnt %0d busy %b/%b rd %h expected cnt 2 busy 0/1 rd 00000055",
                         PENDING_CNT, BUSY1, BUSY2, RD1);
    end
    WE = 1'b1; WA = 4'd5; WD = 32'hDEADBEEF; WSTRB = 4'hF; RES = 1'b1; RES_A = 4'd5; tick();
    RA1 = 4'd5; #1;
    checks++;
    if (PENDING_CNT !== 5'd3 || BUSY1 !== 1'b1 || RD1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sb_set_clr_same: got cnt %0d busy %b rd %h expected cnt 3 busy 1 rd deadbeef", PENDING_CNT, BUSY1, RD1);
    end
    RES = 1'b1; RES_A = 4'd6; tick();
    #1;
    checks++;
    if (PENDING_CNT !== 5'd3) begin
      errors++; $display("FAIL sb_rereserve: got cnt %0d expected 3", PENDING_CNT);
    end
    WE = 1'b1; WA = 4'd6; WD = 32'hFFFFFFFF; WSTRB = 4'h0; tick();
    RA1 = 4'd6; #1;
    checks++;
    if (PENDING_CNT !== 5'd2 || BUSY1 !== 1'b0 || RD1 !== 32'h0) begin
      errors++; $display("FAIL sb_zero_strobe: got cnt %0d busy %b rd %h expected cnt 2 busy 0 rd 00000000", PENDING_CNT, BUSY1, RD1);
    end
  endtask

  task automatic test_zero_reg();
    WE = 1'b1; WA = 4'd0; WD = 32'hFFFFFFFF; WSTRB = 4'hF; RES = 1'b1; RES_A = 4'd0; tick();
    RA1 = 4'd0; RA2 = 4'd0; #1;
    checks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0 || BUSY1 !== 1'b0 || PENDING_CNT !== 5'd2) begin
      errors++; $display("FAIL zero_reg: got rd %h/%h busy %b cnt %0d expected 0/0 busy 0 cnt 2", RD1, RD2, BUSY1, PENDING_CNT);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
    logic        exp_busy;
    WE = 1'b1; WA = 4'd2; WD = 32'hCAFE0001; WSTRB = 4'hF; tick();
    WE = 1'b1; WA = 4'd2; WD = 32'h12345678; WSTRB = 4'hF; RES = 1'b1; RES_A = 4'd9;
    RA1 = 4'd2; RA2 = 4'd9; #1;
`ifdef N_BIT_REGISTER_FILE_BYPASS_EN
    exp_rd = 32'h12345678; exp_busy = 1'b1;
`else
    exp_rd = 32'hCAFE0001; exp_busy = 1'b0;
`endif
    checks++;
    if (RD1 !== exp_rd || BUSY2 !== exp_busy) begin
      errors++; $display("FAIL bypass_pre_edge: got rd %h busy %b expected rd %h busy %b", RD1, BUSY2, exp_rd, exp_busy);
    end
    tick();
    #1;
    checks++;
    if (RD1 !== 32'h12345678 || BUSY2 !== 1'b1 || PENDING_CNT !== 5'd3) begin
      errors++; $display("FAIL bypass_post_edge: got rd %h busy %b cnt %0d expected 12345678 busy 1 cnt 3", RD1, BUSY2, PENDING_CNT);
    end
    WE = 1'b1; WA = 4'd9; WD = 32'h0; WSTRB = 4'h0; #1;
`ifdef N_BIT_REGISTER_FILE_BYPASS_EN
    exp_busy = 1'b0;
`else
    exp_busy = 1'b1;
`endif
    checks++;
    if (BUSY2 !== exp_busy) begin
      errors++; $display("FAIL bypass_busy_clear: got %b expected %b", BUSY2, exp_busy);
    end
    tick();
    #1;
    checks++;
    if (BUSY2 !== 1'b0 || PENDING_CNT !== 5'd2) begin
      errors++; $display("FAIL bypass_busy_after: got busy %b cnt %0d expected 0 cnt 2", BUSY2, PENDING_CNT);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 4; i++) begin
      WE = 1'b1; WA = 4'(8 + i); WD = 32'h10101010 * (i + 1); WSTRB = 4'hF;
      RES = (i < 3); RES_A = 4'(8 + i);
      tick();
    end
    RA1 = 4'd10; #1;
    checks++;
    if (PENDING_CNT !== 5'd5 || RD1 !== 32'h30303030 || BUSY1 !== 1'b1) begin
      errors++; $display("FAIL clr_fill: got cnt %0d rd %h busy %b expected cnt 5 rd 30303030 busy 1", PENDING_CNT, RD1, BUSY1);
    end
    CLR = 1'b1; WE = 1'b1; WA = 4'd12; WD = 32'h77777777; WSTRB = 4'hF; RES = 1'b1; RES_A = 4'd13; tick();
    RA1 = 4'd8; RA2 = 4'd12; #1;
    checks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0 || PENDING_CNT !== 5'd0) begin
      errors++; $display("FAIL clr_state: got rd %h/%h cnt %0d expected 0/0 cnt 0", RD1, RD2, PENDING_CNT);
    end
    RA1 = 4'd13; RA2 = 4'd3; #1;
    checks++;
    if (BUSY1 !== 1'b0 || RD2 !== 32'h0) begin
      errors++; $display("FAIL clr_res_dropped: got busy %b rd %h expected busy 0 rd 00000000", BUSY1, RD2);
    end
  endtask

  task automatic test_async_reset();
    WE = 1'b1; WA = 4'd4; WD = 32'hA5A5A5A5; WSTRB = 4'hF; RES = 1'b1; RES_A = 4'd4; tick();
    RA1 = 4'd4; #1;
    checks++;
    if (RD1 !== 32'hA5A5A5A5 || PENDING_CNT !== 5'd1) begin
      errors++; $display("FAIL async_pre: got rd %h cnt %0d expected a5a5a5a5 cnt 1", RD1, PENDING_CNT);
    end
    #1 RST = 1'b0;
    #1;
    checks++;
    if (RD1 !== 32'h0 || BUSY1 !== 1'b0 || PENDING_CNT !== 5'd0) begin
      errors++; $display("FAIL async_assert: got rd %h busy %b cnt %0d expected 0 busy 0 cnt 0", RD1, BUSY1, PENDING_CNT);
    end
    WE = 1'b1; WA = 4'd4; WD = 32'h1; WSTRB = 4'hF; RES = 1'b1; RES_A = 4'd4;
    tick();
    #1;
    checks++;
    if (RD1 !== 32'h0 || PENDING_CNT !== 5'd0) begin
      errors++; $display("FAIL async_inflight: got rd %h cnt %0d expected 0 cnt 0", RD1, PENDING_CNT);
    end
    @(negedge CLK);
    RST = 1'b1;
    WE = 1'b1; WA = 4'd4; WD = 32'h0BADF00D; WSTRB = 4'hF; tick();
    #1;
    checks++;
    if (RD1 !== 32'h0BADF00D || PENDING_CNT !== 5'd0) begin
      errors++; $display("FAIL async_first_edge: got rd %h cnt %0d expected 0badf00d cnt 0", RD1, PENDING_CNT);
    end
  endtask

  initial begin
    RST = 1'b0; CLR = 1'b0; WE = 1'b0; WA = '0; WD = '0; WSTRB = '0;
    RES = 1'b0; RES_A = '0; RA1 = '0; RA2 = '0;
    test_reset();
    test_byte_strobe();
    test_scoreboard();
    test_zero_reg();
    test_bypass();
    test_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/n_bit_register_file.md
# n_bit_register_file

Parametrised multi-register storage block, the successor to the single write-enabled register. It holds DEPTH words of N bits with one byte-strobed write port, two combinational read ports and a per-register pending scoreboard. It sits between decode and writeback in the processor datapath as the architectural register file. Decode reserves a destination register, and writeback clears the reservation when it writes the result.

## Interface
- N, 32: word width in bits; must be a multiple of 8
- DEPTH, 16: number of registers; power of two, at least 2
- ZERO_REG, 0: when 1, register 0 always reads 0, and writes and reservations to it are ignored
- AW (localparam) = $clog2(DEPTH); NB (localparam) = N/8
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous clear of all registers, pending bits and count; active-high
- WE  in  1  write enable
- WA  in  AW  write address
- WD  in  N  write data
- WSTRB  in  NB  byte-lane enables; bit i controls WD[8i+7:8i]
- RES  in  1  reserve request; sets the pending bit of RES_A
- RES_A  in  AW  register to reserve
- RA1, RA2  in  AW  read addresses
- RD1, RD2  out  N  read data
- BUSY1, BUSY2  out  1  pending bit of RA1 / RA2
- PENDING_CNT  out  AW+1  number of registers currently pending

## Operation
- Priority per edge: RST (asynchronous) > CLR > normal operation.
- Write: when WE=1, each lane of register WA with WSTRB[i]=1 takes WD. Other lanes hold. WE=1 with WSTRB=0 changes no data but still clears pending.
- Any WE=1 clears the pending bit of WA.
- Reserve: RES=1 sets the pending bit of RES_A.
- Write and reserve to the same address in the same cycle: data is written and pending stays 1, because the new producer wins.
- Reserving an already-pending register leaves it pending. The count does not change.
- PENDING_CNT tracks population exactly: +1 on a 0→1 transition, −1 on a 1→0 transition, and net 0 when a set and a clear hit different registers in the same cycle. It can never exceed DEPTH.
- ZERO_REG=1: when address 0 is involved, RD returns 0, BUSY returns 0, and writes and reserves to address 0 have no effect.
- RA1 and RA2 may be equal; both ports return identical values.

## Timing
- Reads are combinational from RA and state. Writes and reservations are visible after the next rising edge, unless bypass is enabled.
- On RST low, immediately and independent of CLK: all registers = 0, pending = 0. As a result RD1 = RD2 = 0, BUSY1 = BUSY2 = 0 and PENDING_CNT = 0.
- Reset asserted mid-operation discards any in-flight write or reserve.
- The first edge after RST deasserts behaves as a normal edge.
- CLR=1 gives the same end state as reset, one edge later. WE and RES in that cycle are ignored.

## Configuration
- N_BIT_REGISTER_FILE_BYPASS_EN, defined:
  - If WE=1 and WA==RAx (and the address is not a forced-zero register 0), RDx returns the stored word with the strobed lanes replaced by WD, in the same cycle.
  - BUSYx returns 0 when the same cycle clears it (write without a reserve to that address).
  - BUSYx returns 1 when RES targets RAx.
- Not defined: reads always reflect state as of the last edge. There are no combinational paths from WD, WE, RES or RES_A to any output.

## Structure
- Package n_bit_register_file_pkg holds:
  - the byte-merge function (old word, new word, strobe → merged word)
  - the lane-width constant 8
- Sub-module regfile_scoreboard holds:
  - the DEPTH pending bits
  - the PENDING_CNT counter
  - set/clear priority
  - the BUSY lookups
- Data storage and the read muxes remain in the top module.

## Test plan
- Reset: hold RST=0 with random inputs toggling. Expect RD1=RD2=0, BUSY=0, PENDING_CNT=0 with no clock edge.
- Byte strobe: write 0xAABBCCDD to r3 with WSTRB=4'hF, then 0x11223344 with WSTRB=4'b0101. Expect RA1=3 → 0xAA22CC44.
- Scoreboard:
  - Reserve r5 and r6 → PENDING_CNT=2, BUSY1=1 at RA1=5.
  - Same cycle: write r5 and reserve r7 → PENDING_CNT=2, r5 not busy.
  - Write r5 and reserve r5 in one cycle → r5 still busy, data updated.
- Zero register with ZERO_REG=1: write 0xFFFFFFFF to r0 and reserve r0. Expect RD=0, BUSY=0, PENDING_CNT unchanged.
- Bypass: write 0x12345678 to r2 with RA1=2 in the same cycle.
  - With the macro: RD1=0x12345678 before the edge.
  - Without it: RD1 shows the old value until after the edge.
- CLR: fill 4 registers and reserve 3. Pulse CLR together with WE=1 → all RD=0, PENDING_CNT=0, and the coincident write is dropped.
